// File: rtl/y86_pipe_pkg.sv
// Shared definitions for the y86 pipeline-stage skid registers: occupancy
// state encodings, y86 bubble constants and per-stage bundle widths.
package y86_pipe_pkg;

    // Number of bundles held by a stage register; the encoding is the count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // y86 instruction / status encodings used to build bubble bundles.
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] F_NONE   = 4'h0;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;

    // Bundle widths of the individual stage registers.
    localparam int F_BUNDLE_W = 64;                          // predPC
    localparam int D_BUNDLE_W = 3 + 4 + 4 + 4 + 4 + 64 + 64; // stat icode ifun rA rB valC valP
    localparam int E_BUNDLE_W = 3 + 4 + 4 + 64 * 3 + 4 * 4;  // stat icode ifun valC valA valB dstE dstM srcA srcB
    localparam int M_BUNDLE_W = 3 + 4 + 1 + 64 * 2 + 4 * 2;  // stat icode Cnd valE valA dstE dstM
    localparam int W_BUNDLE_W = 3 + 4 + 64 * 2 + 4 * 2;      // stat icode valE valM dstE dstM

    // Decode-stage bubble: nop with SBUB status and no register traffic.
    localparam logic [D_BUNDLE_W-1:0] D_BUBBLE =
        {STAT_BUB, I_NOP, F_NONE, REG_NONE, REG_NONE, 64'd0, 64'd0};

endpackage

// File: rtl/y86_pipe_skid_reg_if.sv
// Valid/ready bundle channel between two pipeline stages.
interface y86_pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of the channel.
    modport master (output valid, output data, input ready);
    // Consumer side of the channel.
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module y86_sat_counter #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   inc,
    output logic [STALL_CNT_W-1:0] count
);

    // Count up on inc, hold once every bit is set, clear has priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/y86_pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, registered in_ready,
// bubble (flush) insertion and a saturating stall-cycle counter.
module y86_pipe_skid_reg
    import y86_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL  = '0,
    parameter int               STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    y86_pipe_skid_reg_if.slave     up,
    input  logic                   bubble,
    y86_pipe_skid_reg_if.master    down,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    occ_e             state, state_next;
    logic [WIDTH-1:0] main_data, main_next;
    logic [WIDTH-1:0] skid_data, skid_next;
    logic             in_ready_q;
    logic             accept, send;

    assign up.ready   = in_ready_q;
    assign down.valid = (state != OCC_EMPTY);
    assign down.data  = main_data;
    assign occupancy  = state;

    assign accept = up.valid & in_ready_q;
    assign send   = down.valid & down.ready;

    // Next occupancy and register contents from the handshake and bubble.
    always_comb begin
        state_next = state;
        main_next  = main_data;
        skid_next  = skid_data;
        unique case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    state_next = OCC_ONE;
                    main_next  = up.data;
                end
            end
            OCC_ONE: begin
                if (accept && send) begin
                    main_next = up.data;
                end else if (accept) begin
                    state_next = OCC_FULL;
                    skid_next  = up.data;
                end else if (send) begin
                    state_next = OCC_EMPTY;
                    main_next  = BUBBLE_VAL;
                end
            end
            OCC_FULL: begin
                if (send) begin
                    state_next = OCC_ONE;
                    main_next  = skid_data;
                end
            end
            default: begin
                state_next = OCC_EMPTY;
                main_next  = BUBBLE_VAL;
            end
        endcase
        // A flush wins over every transfer; any accepted bundle is dropped.
        if (bubble) begin
            state_next = OCC_EMPTY;
            main_next  = BUBBLE_VAL;
        end
    end

    // State, output register and the registered in_ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OCC_EMPTY;
            main_data  <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            main_data  <= main_next;
            in_ready_q <= (state_next != OCC_FULL);
        end
    end

    // Skid storage is only meaningful while FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_data <= skid_next;
    end

    y86_sat_counter #(
        .STALL_CNT_W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (down.valid & ~down.ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_y86_pipe_skid_reg.sv
// Bench for y86_pipe_skid_reg: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_y86_pipe_skid_reg;

    localparam int          WIDTH      = 32;
    localparam logic [31:0] RESET_VAL  = 32'hDEAD_0000;
    localparam logic [31:0] BUBBLE_VAL = 32'h0000_0B0B;
    localparam int          CNT_W      = 4;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             bubble;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    y86_pipe_skid_reg_if #(.WIDTH(WIDTH)) up_if ();
    y86_pipe_skid_reg_if #(.WIDTH(WIDTH)) down_if ();

    y86_pipe_skid_reg #(
        .WIDTH      (WIDTH),
        .RESET_VAL  (RESET_VAL),
        .BUBBLE_VAL (BUBBLE_VAL),
        .STALL_CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (up_if),
        .bubble   (bubble),
        .down     (down_if),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of held bundles, value shown while empty, counter.
    logic [31:0] mq[$];
    logic [31:0] m_empty_val;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic iv, input logic [31:0] d,
                              input logic b, input logic ordy);
        bit acc, snd;
        if (r) begin
            mq.delete();
            m_empty_val = RESET_VAL;
            m_cnt = 0;
            return;
        end
        acc = iv && (mq.size() < 2);
        snd = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
        if (snd) void'(mq.pop_front());
        if (b) begin
            mq.delete();
            m_empty_val = BUBBLE_VAL;
        end else begin
            if (acc) mq.push_back(d);
            if (snd && mq.size() == 0) m_empty_val = BUBBLE_VAL;
        end
    endtask

    task automatic check_all();
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("out_valid", 32'(down_if.valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(up_if.ready), 32'(mq.size() != 2));
        chk("out_data", down_if.data, (mq.size() != 0) ? mq[0] : m_empty_val);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic r, input logic iv, input logic [31:0] d,
                        input logic b, input logic ordy);
        reset         = r;
        up_if.valid   = iv;
        up_if.data    = d;
        bubble        = b;
        down_if.ready = ordy;
        @(posedge clk);
        model_edge(r, iv, d, b, ordy);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; bubble = 1'b0;
        up_if.valid = 1'b0; up_if.data = '0; down_if.ready = 1'b0;
        m_empty_val = RESET_VAL; m_cnt = 0;
        @(negedge clk);

        // Reset overrides bubble and a pending input.
        step(1, 1, 32'hAAAA_0001, 1, 0);
        step(1, 1, 32'hAAAA_0001, 1, 0);
        chk("reset_data", down_if.data, RESET_VAL);

        // Streaming at full rate.
        step(0, 1, 32'h100, 0, 1);
        chk("stream_first", down_if.data, 32'h100);
        step(0, 1, 32'h104, 0, 1);
        step(0, 1, 32'h108, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        chk("stream_cnt", 32'(stall_cnt), 32'd0);

        // Skid fill, three held cycles, then drain.
        step(0, 1, 32'h10, 0, 0);
        step(0, 1, 32'h14, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0);
        chk("skid_cnt", 32'(stall_cnt), 32'd4);
        chk("skid_hold", down_if.data, 32'h10);
        step(0, 0, 32'h0, 0, 1);
        chk("skid_second", down_if.data, 32'h14);
        step(0, 0, 32'h0, 0, 1);

        // Bubble while FULL with a valid input that must be dropped.
        step(0, 1, 32'h30, 0, 0);
        step(0, 1, 32'h34, 0, 0);
        step(0, 1, 32'h55, 1, 0);
        chk("bub_full_data", down_if.data, BUBBLE_VAL);
        step(0, 0, 32'h0, 0, 1);

        // Bubble together with a send.
        step(0, 1, 32'h20, 0, 0);
        step(0, 0, 32'h0, 1, 1);
        chk("bub_send_occ", 32'(occupancy), 32'd0);

        // Counter saturation, bubble leaves it, reset clears it.
        step(0, 1, 32'h40, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 0, 0);
        chk("sat_top", 32'(stall_cnt), 32'(CNT_MAX));
        step(0, 0, 32'h0, 1, 0);
        chk("sat_bubble", 32'(stall_cnt), 32'(CNT_MAX));
        step(1, 0, 32'h0, 0, 0);
        chk("sat_reset", 32'(stall_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 ($urandom_range(0, 19) == 0),
                 ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/y86_pipe_skid_reg.md
Name: y86_pipe_skid_reg

Overview:
- Parametrised successor to the y86 pipeline-stage registers (F/D/E/M/W). Carries a WIDTH-bit stage bundle between two pipeline stages.
- Replaces the global stall wire with a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, so backpressure never forms a combinational path across stages.
- Adds bubble (flush) insertion with a programmable bubble value, and a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 32, bit width of the stage bundle (predPC, icode, valC, etc., packed by the instantiating stage).
- RESET_VAL, 0, value of out_data after reset.
- BUBBLE_VAL, 0, value of out_data whenever the stage is empty or flushed (e.g. the nop/SBUB encoding).
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept; driven directly from a flop
- in_data  input  WIDTH  upstream bundle
- bubble  input  1  flush: discard all held entries and present BUBBLE_VAL
- out_valid  output  1  out_data holds a real bundle
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  bundle to next stage
- occupancy  output  2  entries held (0..2)
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state updates on the clk rising edge; no asynchronous paths.
- Reset (reset=1 at an edge): out_valid=0, out_data=RESET_VAL, in_ready=1, occupancy=0, stall_cnt=0. Reset overrides bubble and every handshake. Any entries held when reset is asserted mid-operation are lost.
- Storage: main register (drives out_data and out_valid) and skid register. Transfers:
  - accept = in_valid & in_ready
  - send = out_valid & out_ready
- States, encoded as occupancy:
  - EMPTY(0):
    - accept -> ONE; main <= in_data.
    - Otherwise stays EMPTY; out_data = BUBBLE_VAL.
  - ONE(1):
    - accept & send -> ONE; main <= in_data.
    - accept & !send -> FULL; skid <= in_data; in_ready <= 0.
    - !accept & send -> EMPTY; out_data <= BUBBLE_VAL.
    - Otherwise holds.
  - FULL(2): in_ready=0, so no accept.
    - send -> ONE; main <= skid; in_ready <= 1.
    - Otherwise holds.
- Latency: one cycle from accept to out_valid when the stage is EMPTY or draining. Throughput is one bundle per cycle while out_ready=1.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_valid are stable (the old F_stall behaviour).
- bubble=1 (reset=0), priority over all transfers:
  - Next state is EMPTY: out_valid <= 0, out_data <= BUBBLE_VAL, in_ready <= 1, skid discarded.
  - An accept in the same cycle completes the handshake, but its data is dropped.
  - A send in the same cycle completes normally; downstream consumes the old bundle.
- stall_cnt: increments each cycle with out_valid & !out_ready. Holds at all-ones. Cleared only by reset; bubble does not clear it.
- Invariants:
  - in_ready == (occupancy != 2)
  - out_valid == (occupancy != 0)
  - occupancy never exceeds 2.
  - out_data == BUBBLE_VAL whenever out_valid=0 after any bubble or drain.

Decomposition:
- Shared package y86_pipe_pkg:
  - occupancy state encodings (OCC_EMPTY, OCC_ONE, OCC_FULL);
  - y86 bubble constants (nop bundle value, SBUB status) used as BUBBLE_VAL by each stage;
  - per-stage bundle width constants.
- One natural sub-module: y86_sat_counter (STALL_CNT_W, inc, clear → count, saturating). Register and control logic stay in the top module.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1, in_data=0xAAAA_0001, bubble=1 -> out_valid=0, out_data=RESET_VAL, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, send 0x100, 0x104, 0x108 on consecutive cycles -> each appears on out_data exactly one cycle later; in_ready stays 1; stall_cnt stays 0.
- Skid fill and drain: accept 0x10, then 0x14 with out_ready=0, then hold out_ready=0 for 3 cycles:
  - in_ready goes 0 after the second accept; occupancy=2; out_data held at 0x10; stall_cnt=4.
  - Raising out_ready then yields 0x10, then 0x14, with in_ready returning to 1 one cycle after the first send.
- Bubble while FULL, with in_valid=1 and in_data=0x55: next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1; 0x55 never appears.
- Bubble with send: in ONE holding 0x20, out_ready=1 and bubble=1 in the same cycle -> 0x20 consumed once, then the stage is EMPTY.
- Saturation: STALL_CNT_W=4, stall for 20 cycles -> stall_cnt stops at 15; a bubble leaves it at 15; reset clears it to 0.
